dff_nibble_loader: RTL and testbench



---
 rtl/dff_pkg.sv | 19 +
 rtl/dff_nibble_loader_sat_counter.sv | 19 +
 rtl/dff_nibble_loader.sv | 113 +++++++++++
 tb/tb_dff_nibble_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
// Shared definitions for the serial front ends feeding the 4-bit register:
// state encoding, default data width and the even-parity helper.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t COLLECT = 2'd0;
  localparam state_t PARITY  = 2'd1;
  localparam state_t LOAD    = 2'd2;
  localparam state_t ERROR   = 2'd3;

  // Zero-extension does not change parity, so narrower words pass straight in.
  function automatic logic parity_even(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dff_nibble_loader_sat_counter.sv
// Saturating up-counter: counts inc cycles and sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/dff_nibble_loader.sv
// Parity-checked serial-to-parallel loader for the enabled register: assembles
// WIDTH bits LSB-first, strobes en on good frames and err on bad ones.
module dff_nibble_loader
  import dff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] d,
  output logic             en,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int BW = $clog2(WIDTH + 1);

  // Handshake: a bit moves on a cycle where s_valid && s_ready at the rising
  // edge; s_ready depends on the current state only, never on s_valid.
  state_t           state;
  state_t           state_next;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             xfer;
  logic             parity_ok;

  assign xfer      = s_valid && s_ready;
  assign parity_ok = (s_bit == parity_even(32'(shreg)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= COLLECT;
      bit_cnt <= '0;
      shreg   <= '0;
      d       <= '0;
    end else begin
      state <= state_next;
      case (state)
        COLLECT: begin
          if (abort) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end else if (xfer) begin
            // shreg is cleared at every frame start, so OR-ing places the bit
            shreg   <= shreg | (WIDTH'(s_bit) << bit_cnt);
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        PARITY: begin
          if (abort) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end else if (xfer && parity_ok) begin
            d <= shreg;
          end
        end
        default: begin
          bit_cnt <= '0;
          shreg   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (abort) state_next = COLLECT;
        else if (xfer && (bit_cnt == BW'(WIDTH - 1))) state_next = PARITY;
      end
      PARITY: begin
        if (abort) state_next = COLLECT;
        else if (xfer) state_next = parity_ok ? LOAD : ERROR;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    en      = 1'b0;
    err     = 1'b0;
    case (state)
      COLLECT: s_ready = 1'b1;
      PARITY:  s_ready = 1'b1;
      LOAD:    en      = 1'b1;
      ERROR:   err     = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_frame_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (en),
    .q       (frame_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (err),
    .q       (err_cnt)
  );

endmodule

// File: tb/tb_dff_nibble_loader.sv
// Directed bench for dff_nibble_loader: frame table plus abort, reset and
// saturation sequences, with a downstream register model and an en scoreboard.
module tb_dff_nibble_loader;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_bit = 1'b0;
  logic          abort = 1'b0;
  logic          s_ready;
  logic          en;
  logic          err;
  logic [W-1:0]  d;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  always #5 clk = ~clk;

  dff_nibble_loader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_valid   (s_valid),
    .s_bit     (s_bit),
    .s_ready   (s_ready),
    .abort     (abort),
    .d         (d),
    .en        (en),
    .err       (err),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  int en_seen = 0;
  int err_seen = 0;
  int cyc = 0;
  int last_en = -1;
  int period_bad = 0;
  int sready_bad = 0;
  int both_bad = 0;
  bit period_chk = 1'b0;
  int exp_frames = 0;
  int exp_errs = 0;
  logic [W-1:0] q_ds;

  typedef struct {
    logic [W-1:0] data;
    logic         par;
    logic         good;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Downstream enabled register model
  always @(posedge clk) begin
    if (!reset_n) q_ds <= '0;
    else if (en) q_ds <= d;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (s_ready !== !(en || err)) sready_bad++;
      if (en && err) both_bad++;
      if (en) begin
        en_seen++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_en: got en=1 with d=%0h, expected no pulse", d);
        end else begin
          check("en_d", d, exp_q.pop_front());
        end
        if (period_chk && last_en >= 0 && (cyc - last_en) != 6) period_bad++;
        last_en = cyc;
      end
      if (err) err_seen++;
    end
  end

  task automatic send_bit(input logic b, input bit gap);
    int guard;
    guard = 0;
    if (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_bit   = b;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic par, input bit gap);
    for (int i = 0; i < W; i++) send_bit(data[i], gap);
    send_bit(par, gap);
  endtask

  // Leaves the LOAD/ERROR cycle behind and samples one cycle later
  task automatic settle();
    @(negedge clk);
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int e0;
    int r0;
    logic [W-1:0] k_data;

    vecs[0] = '{data: 4'hB, par: 1'b1, good: 1'b1, exp_d: 4'hB};
    vecs[1] = '{data: 4'hB, par: 1'b0, good: 1'b0, exp_d: 4'hB};
    vecs[2] = '{data: 4'h0, par: 1'b0, good: 1'b1, exp_d: 4'h0};
    vecs[3] = '{data: 4'hF, par: 1'b0, good: 1'b1, exp_d: 4'hF};
    vecs[4] = '{data: 4'h7, par: 1'b0, good: 1'b0, exp_d: 4'hF};
    vecs[5] = '{data: 4'h8, par: 1'b1, good: 1'b1, exp_d: 4'h8};
    vecs[6] = '{data: 4'h5, par: 1'b0, good: 1'b1, exp_d: 4'h5};

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_d", d, 0);
    check("rst_en", en, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);

    for (int i = 0; i < 7; i++) begin
      e0 = en_seen;
      r0 = err_seen;
      if (vecs[i].good) begin
        exp_q.push_back(vecs[i].data);
        exp_frames++;
      end else begin
        exp_errs++;
      end
      send_frame(vecs[i].data, vecs[i].par, 1'b0);
      settle();
      check("vec_en_count", en_seen - e0, vecs[i].good ? 1 : 0);
      check("vec_err_count", err_seen - r0, vecs[i].good ? 0 : 1);
      check("vec_d", d, vecs[i].exp_d);
      check("vec_frame_cnt", frame_cnt, sat(exp_frames));
      check("vec_err_cnt", err_cnt, sat(exp_errs));
      if (i == 0) check("downstream_q", q_ds, 4'hB);
    end

    // Abort mid-collection, then a gapped frame
    e0 = en_seen;
    r0 = err_seen;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    s_valid = 1'b1;
    s_bit = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    s_valid = 1'b0;
    exp_q.push_back(4'h6);
    exp_frames++;
    send_frame(4'h6, 1'b0, 1'b1);
    settle();
    check("abort_en_count", en_seen - e0, 1);
    check("abort_err_count", err_seen - r0, 0);
    check("abort_d", d, 4'h6);
    check("abort_frame_cnt", frame_cnt, sat(exp_frames));

    // Abort coincides with a correct parity bit
    e0 = en_seen;
    r0 = err_seen;
    for (int i = 0; i < W; i++) send_bit((i < 2) ? 1'b1 : 1'b0, 1'b0);
    @(negedge clk);
    abort = 1'b1;
    s_valid = 1'b1;
    s_bit = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_par_en_count", en_seen - e0, 0);
    check("abort_par_err_count", err_seen - r0, 0);
    check("abort_par_d", d, 4'h6);
    exp_q.push_back(4'h9);
    exp_frames++;
    send_frame(4'h9, 1'b0, 1'b0);
    settle();
    check("after_abort_en_count", en_seen - e0, 1);
    check("after_abort_d", d, 4'h9);

    // Reset after three data bits
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_frames = 0;
    exp_errs = 0;
    @(negedge clk);
    check("midrst_d", d, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
    e0 = en_seen;
    r0 = err_seen;
    exp_q.push_back(4'h5);
    exp_frames++;
    send_frame(4'h5, 1'b0, 1'b0);
    settle();
    check("midrst_en_count", en_seen - e0, 1);
    check("midrst_err_seen", err_seen - r0, 0);
    check("midrst_frame_d", d, 4'h5);
    check("midrst_frame_cnt1", frame_cnt, 1);

    // Back-to-back good frames drive frame_cnt into saturation
    e0 = en_seen;
    last_en = -1;
    period_chk = 1'b1;
    for (int k = 0; k < 300; k++) begin
      k_data = W'(k);
      exp_q.push_back(k_data);
      exp_frames++;
      send_frame(k_data, ^k_data, 1'b0);
    end
    settle();
    period_chk = 1'b0;
    check("b2b_en_count", en_seen - e0, 300);
    check("b2b_period", period_bad, 0);
    check("b2b_frame_cnt_sat", frame_cnt, sat(exp_frames));
    check("b2b_err_cnt", err_cnt, 0);

    check("s_ready_decode", sready_bad, 0);
    check("en_err_exclusive", both_bad, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
